// File: rtl/bunch_timing_gen.sv
// Multi-bunch strobe / LUT-pulse generator: counts samples during a store window and strobes each bunch.
// Define BUNCH_ONEHOT_EN to drive the per-bunch one-hot strobe; otherwise bunch_strb_oh is tied low.
module bunch_timing_gen #(
    parameter int CNT_W       = 8,
    parameter int NB_W        = 3,
    parameter int MAX_BUNCHES = 4,
    parameter int NS_W        = 4,
    parameter int LUT_OFFSET  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   store_strb,
    input  logic [CNT_W-1:0]       b1_strobe,
    input  logic [CNT_W-1:0]       lut_strobe,
    input  logic [NB_W-1:0]        no_bunches,
    input  logic [NS_W-1:0]        no_samples,
    input  logic [CNT_W-1:0]       sample_spacing,
    output logic                   bunch_strb,
    output logic [NB_W-1:0]        bunch_idx,
    output logic [MAX_BUNCHES-1:0] bunch_strb_oh,
    output logic                   lut_cond,
    output logic                   seq_done,
    output logic                   cfg_err
);
    typedef enum logic [1:0] {IDLE, WAIT, STROBE, DONE} state_t;

    localparam logic [NB_W-1:0]  MAX_B   = NB_W'(MAX_BUNCHES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W+1:0] END_MAX = {2'b00, CNT_MAX};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   i_q, i_d;
    logic               store_prev_q;
    logic [NB_W-1:0]    nb_q;
    logic [NS_W-1:0]    ns_q;
    logic [CNT_W-1:0]   sp_q;
    logic [CNT_W:0]     s_q, s_d;
    logic [CNT_W:0]     t_q, t_d;
    logic [NB_W-1:0]    k_q, k_d;
    logic [NB_W-1:0]    lk_q, lk_d;
    logic [NS_W-1:0]    w_cnt_q, w_cnt_d;
    logic               lut_act_q, lut_act_d;
    logic               strb_q, strb_d;
    logic [NB_W-1:0]    idx_q, idx_d;
    logic               lut_q, lut_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [NB_W-1:0]    n_eff, k_inc;
    logic [NS_W-1:0]    w_eff;
    logic [CNT_W+1:0]   w_ext;
    logic [CNT_W:0]     s_next;
    logic               ovf_cur, ovf_next, sp_err, hit_cur, hit_next, rise;

    always_comb begin
        n_eff    = (nb_q > MAX_B) ? MAX_B : nb_q;
        w_eff    = (ns_q == '0) ? NS_W'(1) : ns_q;
        w_ext    = (CNT_W+2)'(w_eff);
        s_next   = s_q + {1'b0, sp_q};
        // Last sample of a window must still fit in the counter range.
        ovf_cur  = ({1'b0, s_q} + w_ext - (CNT_W+2)'(1)) > END_MAX;
        ovf_next = ({1'b0, s_next} + w_ext - (CNT_W+2)'(1)) > END_MAX;
        sp_err   = (n_eff >= NB_W'(2)) && ({2'b00, sp_q} < w_ext);
        hit_cur  = !s_q[CNT_W] && (i_q == s_q[CNT_W-1:0]);
        hit_next = !s_next[CNT_W] && (i_q == s_next[CNT_W-1:0]);
        rise     = store_strb && !store_prev_q;
        k_inc    = k_q + NB_W'(1);
        i_d      = !store_strb ? '0 : ((i_q == CNT_MAX) ? i_q : i_q + CNT_W'(1));
    end

    // Bunch sequencer
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        w_cnt_d = w_cnt_q;
        strb_d  = 1'b0;
        idx_d   = idx_q;
        done_d  = 1'b0;
        err_d   = err_q;
        if (!store_strb) begin
            state_d = IDLE;
            s_d     = {1'b0, b1_strobe};
            k_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        err_d = 1'b0;
                        k_d   = '0;
                        if (n_eff == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else if (sp_err || ovf_cur) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else if (hit_cur) begin
                            state_d = STROBE;
                            strb_d  = 1'b1;
                            idx_d   = '0;
                            w_cnt_d = w_eff - NS_W'(1);
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (hit_cur) begin
                        state_d = STROBE;
                        strb_d  = 1'b1;
                        idx_d   = k_q;
                        w_cnt_d = w_eff - NS_W'(1);
                    end
                end
                STROBE: begin
                    if (w_cnt_q != '0) begin
                        strb_d  = 1'b1;
                        w_cnt_d = w_cnt_q - NS_W'(1);
                    end else begin
                        k_d = k_inc;
                        s_d = s_next;
                        if (k_inc == n_eff) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else if (ovf_next) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else if (hit_next) begin
                            // spacing == width: next window starts without a gap
                            strb_d  = 1'b1;
                            idx_d   = k_inc;
                            w_cnt_d = w_eff - NS_W'(1);
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // LUT targets run on their own register, independent of the bunch sequencer
    always_comb begin
        t_d       = t_q;
        lk_d      = lk_q;
        lut_d     = 1'b0;
        lut_act_d = lut_act_q;
        if (!store_strb) begin
            t_d       = {1'b0, lut_strobe} + (CNT_W+1)'(LUT_OFFSET);
            lk_d      = '0;
            lut_act_d = 1'b0;
        end else begin
            if (rise)
                lut_act_d = 1'b1;
            if ((rise || lut_act_q) && (lk_q < n_eff) && !t_q[CNT_W] &&
                (i_q == t_q[CNT_W-1:0])) begin
                lut_d = 1'b1;
                lk_d  = lk_q + NB_W'(1);
                t_d   = t_q + {1'b0, sp_q};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            i_q          <= '0;
            store_prev_q <= 1'b1;  // a store already high at release is not a start
            nb_q         <= '0;
            ns_q         <= '0;
            sp_q         <= '0;
            s_q          <= '0;
            t_q          <= '0;
            k_q          <= '0;
            lk_q         <= '0;
            w_cnt_q      <= '0;
            lut_act_q    <= 1'b0;
            strb_q       <= 1'b0;
            idx_q        <= '0;
            lut_q        <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            store_prev_q <= store_strb;
            if (!store_strb) begin
                nb_q <= no_bunches;
                ns_q <= no_samples;
                sp_q <= sample_spacing;
            end
            s_q          <= s_d;
            t_q          <= t_d;
            k_q          <= k_d;
            lk_q         <= lk_d;
            w_cnt_q      <= w_cnt_d;
            lut_act_q    <= lut_act_d;
            strb_q       <= strb_d;
            idx_q        <= idx_d;
            lut_q        <= lut_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bunch_strb = strb_q;
    assign bunch_idx  = idx_q;
    assign lut_cond   = lut_q;
    assign seq_done   = done_q;
    assign cfg_err    = err_q;

`ifdef BUNCH_ONEHOT_EN
    logic [MAX_BUNCHES-1:0] oh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            oh_q <= '0;
        else
            oh_q <= strb_d ? (MAX_BUNCHES'(1) << idx_d) : '0;
    end

    assign bunch_strb_oh = oh_q;
`else
    assign bunch_strb_oh = '0;
`endif

endmodule

// File: tb/tb_bunch_timing_gen.sv
// Directed bench for bunch_timing_gen: per-cycle traces compared against hand-built expected traces.
module tb_bunch_timing_gen;
    localparam int MAXL = 320;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       store_strb = 1'b0;
    logic [7:0] b1_strobe = '0;
    logic [7:0] lut_strobe = '0;
    logic [2:0] no_bunches = '0;
    logic [3:0] no_samples = '0;
    logic [7:0] sample_spacing = '0;
    logic       bunch_strb, lut_cond, seq_done, cfg_err;
    logic [2:0] bunch_idx;
    logic [3:0] bunch_strb_oh;

    int n_vec = 0;
    int n_err = 0;

    logic       o_strb [MAXL];
    logic       o_lut  [MAXL];
    logic       o_done [MAXL];
    logic       o_err  [MAXL];
    logic [2:0] o_idx  [MAXL];
    logic [3:0] o_oh   [MAXL];
    logic       e_strb [MAXL];
    logic       e_lut  [MAXL];
    logic       e_done [MAXL];
    logic       e_err  [MAXL];
    logic [2:0] e_idx  [MAXL];

    bunch_timing_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .store_strb     (store_strb),
        .b1_strobe      (b1_strobe),
        .lut_strobe     (lut_strobe),
        .no_bunches     (no_bunches),
        .no_samples     (no_samples),
        .sample_spacing (sample_spacing),
        .bunch_strb     (bunch_strb),
        .bunch_idx      (bunch_idx),
        .bunch_strb_oh  (bunch_strb_oh),
        .lut_cond       (lut_cond),
        .seq_done       (seq_done),
        .cfg_err        (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, expv);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " strb"}, 32'(bunch_strb), 32'd0);
        check({tag, " idx"},  32'(bunch_idx), 32'd0);
        check({tag, " oh"},   32'(bunch_strb_oh), 32'd0);
        check({tag, " lut"},  32'(lut_cond), 32'd0);
        check({tag, " done"}, 32'(seq_done), 32'd0);
        check({tag, " err"},  32'(cfg_err), 32'd0);
    endtask

    task automatic exp_clear(input logic [2:0] idx0, input logic err0);
        for (int j = 0; j < MAXL; j++) begin
            e_strb[j] = 1'b0;
            e_lut[j]  = 1'b0;
            e_done[j] = 1'b0;
            e_idx[j]  = idx0;
            e_err[j]  = (j == 0) ? err0 : 1'b0;
        end
    endtask

    // window for count s of width w, bunch k: strobe at i = s+1 .. s+w
    task automatic exp_win(input int s, input int w, input logic [2:0] k);
        for (int j = s + 1; j < MAXL; j++) begin
            e_idx[j] = k;
            if (j <= s + w) e_strb[j] = 1'b1;
        end
    endtask

    task automatic exp_err_from(input int j0);
        for (int j = j0; j < MAXL; j++) e_err[j] = 1'b1;
    endtask

    // trace index j is the cycle in which the sample counter equals j
    task automatic run_seq(input logic [7:0] b1, input logic [7:0] lut, input logic [7:0] sp,
                           input logic [2:0] nb, input logic [3:0] ns, input int len, input int fall_j);
        @(negedge clk);
        store_strb     = 1'b0;
        b1_strobe      = b1;
        lut_strobe     = lut;
        sample_spacing = sp;
        no_bunches     = nb;
        no_samples     = ns;
        @(negedge clk);
        @(negedge clk);
        store_strb = 1'b1;
        for (int j = 0; j < len; j++) begin
            if (j > 0) @(negedge clk);
            o_strb[j] = bunch_strb;
            o_lut[j]  = lut_cond;
            o_done[j] = seq_done;
            o_err[j]  = cfg_err;
            o_idx[j]  = bunch_idx;
            o_oh[j]   = bunch_strb_oh;
            if (j == 1) begin
                b1_strobe      = ~b1;
                lut_strobe     = ~lut;
                sample_spacing = sp ^ 8'h0F;
                no_bunches     = ~nb;
                no_samples     = ~ns;
            end
            if (j == fall_j - 1) store_strb = 1'b0;
        end
    endtask

    task automatic cmp_trace(input string sc, input int len);
        logic [3:0] oh_exp;
        for (int j = 0; j < len; j++) begin
            check($sformatf("%s strb@%0d", sc, j), 32'(o_strb[j]), 32'(e_strb[j]));
            check($sformatf("%s lut@%0d", sc, j),  32'(o_lut[j]),  32'(e_lut[j]));
            check($sformatf("%s done@%0d", sc, j), 32'(o_done[j]), 32'(e_done[j]));
            check($sformatf("%s err@%0d", sc, j),  32'(o_err[j]),  32'(e_err[j]));
            check($sformatf("%s idx@%0d", sc, j),  32'(o_idx[j]),  32'(e_idx[j]));
`ifdef BUNCH_ONEHOT_EN
            oh_exp = e_strb[j] ? (4'b0001 << e_idx[j]) : 4'b0000;
`else
            oh_exp = 4'b0000;
`endif
            check($sformatf("%s oh@%0d", sc, j), 32'(o_oh[j]), 32'(oh_exp));
        end
        $display("scenario %s: %0d cycles compared", sc, len);
    endtask

    task automatic exp_scenario_a();
        exp_clear(3'd0, 1'b0);
        exp_win(10, 2, 3'd0);
        exp_win(30, 2, 3'd1);
        exp_win(50, 2, 3'd2);
        e_done[53] = 1'b1;
        e_lut[9] = 1'b1; e_lut[29] = 1'b1; e_lut[49] = 1'b1;
    endtask

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout, want $finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // three bunches, LUT at 9/29/49
        run_seq(8'd10, 8'd5, 8'd20, 3'd3, 4'd2, 100, 0);
        exp_scenario_a();
        cmp_trace("A", 100);

        // two bunches, width 0 treated as 1, LUT at 9/29 only
        run_seq(8'd100, 8'd5, 8'd20, 3'd2, 4'd0, 140, 0);
        exp_clear(3'd2, 1'b0);
        exp_win(100, 1, 3'd0);
        exp_win(120, 1, 3'd1);
        e_done[122] = 1'b1;
        e_lut[9] = 1'b1; e_lut[29] = 1'b1;
        cmp_trace("B", 140);

        // spacing < width: error, no strobes; LUT still fires
        run_seq(8'd10, 8'd5, 8'd1, 3'd2, 4'd4, 40, 0);
        exp_clear(3'd1, 1'b0);
        exp_err_from(1);
        e_done[1] = 1'b1;
        e_lut[9] = 1'b1; e_lut[10] = 1'b1;
        cmp_trace("C", 40);

        // back-to-back windows clear the error, continuous strobe 6..11
        run_seq(8'd5, 8'd0, 8'd3, 3'd2, 4'd3, 20, 0);
        exp_clear(3'd1, 1'b1);
        exp_win(5, 3, 3'd0);
        exp_win(8, 3, 3'd1);
        e_done[12] = 1'b1;
        e_lut[4] = 1'b1; e_lut[7] = 1'b1;
        cmp_trace("D", 20);

        // first window overflows; counter runs into saturation, LUT target 255
        run_seq(8'd253, 8'd252, 8'd0, 3'd1, 4'd4, 300, 0);
        exp_clear(3'd1, 1'b0);
        exp_err_from(1);
        e_done[1] = 1'b1;
        e_lut[256] = 1'b1;
        cmp_trace("E", 300);

        // third window overflows after two good ones; second LUT target skipped
        run_seq(8'd200, 8'd250, 8'd30, 3'd3, 4'd4, 260, 0);
        exp_clear(3'd1, 1'b1);
        exp_win(200, 4, 3'd0);
        exp_win(230, 4, 3'd1);
        exp_err_from(235);
        e_done[235] = 1'b1;
        e_lut[254] = 1'b1;
        cmp_trace("F", 260);

        // request 7 bunches, clamped to 4
        run_seq(8'd2, 8'd0, 8'd2, 3'd7, 4'd1, 16, 0);
        exp_clear(3'd1, 1'b1);
        exp_win(2, 1, 3'd0);
        exp_win(4, 1, 3'd1);
        exp_win(6, 1, 3'd2);
        exp_win(8, 1, 3'd3);
        e_done[10] = 1'b1;
        e_lut[4] = 1'b1; e_lut[6] = 1'b1; e_lut[8] = 1'b1; e_lut[10] = 1'b1;
        cmp_trace("G", 16);

        // store drops inside the first window: strobe cut, no done
        run_seq(8'd10, 8'd5, 8'd20, 3'd3, 4'd2, 32, 12);
        exp_clear(3'd3, 1'b0);
        exp_win(10, 1, 3'd0);
        e_lut[9] = 1'b1;
        cmp_trace("H", 32);

        // reset asserted inside the second window
        run_seq(8'd10, 8'd5, 8'd20, 3'd3, 4'd2, 33, 0);
        exp_scenario_a();
        cmp_trace("I", 33);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        check_all_zero("held_rst");
        rst_n = 1'b1;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            check($sformatf("J strb@%0d", j), 32'(bunch_strb), 32'd0);
            check($sformatf("J lut@%0d", j),  32'(lut_cond), 32'd0);
            check($sformatf("J done@%0d", j), 32'(seq_done), 32'd0);
        end
        $display("scenario J: store high at reset release ignored");

        // normal sequence after that
        run_seq(8'd10, 8'd5, 8'd20, 3'd3, 4'd2, 100, 0);
        exp_scenario_a();
        cmp_trace("K", 100);

        @(negedge clk);
        store_strb = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
